exec_controller: RTL
====================

# exec_controller

Parametrised execution controller that replaces the free-running clock-enable generator feeding every sequential block of the microcoded CPU. Produces the single `o_clk_en` strobe from a programmable divider and adds run, cycle-step and instruction-step modes, N PC breakpoints and sticky HLT capture. Sits between the top-level clock and all `clk_en` consumers. Observes the program counter, the step-0 (fetch) boundary and the HLT control bit.

## Interface
- `DIV_WIDTH`, 16: width of the divider setting.
- `PC_WIDTH`, 16: width of the program counter and breakpoint addresses.
- `NUM_BP`, 4: number of breakpoint comparators (1..16).
- `CNT_WIDTH`, 32: width of the issued-tick counter.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `i_rst_n`  in  1: reset, synchronous, active-low.
- `i_mode`  in  2: 0 = RUN, 1 = STEP_CYCLE, 2 = STEP_INSTR, 3 = reserved (treated as STEP_CYCLE). Sampled only with `i_start`.
- `i_start`  in  1: one-cycle pulse; begins execution in `i_mode`.
- `i_stop`  in  1: one-cycle pulse; stops RUN/STEP at the next tick slot.
- `i_div`  in  DIV_WIDTH: tick period minus 1; 0 gives a tick every cycle.
- `i_halt`  in  1: CPU HLT control bit.
- `i_instr_boundary`  in  1: high when the instruction step counter is 0.
- `i_pc`  in  PC_WIDTH: current program counter.
- `i_bp_en`  in  NUM_BP: per-breakpoint enable.
- `i_bp_addr`  in  NUM_BP*PC_WIDTH: breakpoint k occupies bits [k*PC_WIDTH +: PC_WIDTH].
- `o_clk_en`  out  1: registered tick strobe to all clocked blocks.
- `o_state`  out  3: 0 STOPPED, 1 RUNNING, 2 STEPPING, 3 BREAK, 4 HALTED.
- `o_bp_hit`  out  1: high while in BREAK.
- `o_bp_index`  out  $clog2(NUM_BP) (min 1): index of the breakpoint that caused BREAK.
- `o_tick_count`  out  CNT_WIDTH: number of `o_clk_en` pulses issued; wraps.

## Operation
- Reset values: state STOPPED, `o_clk_en`=0, `o_bp_hit`=0, `o_bp_index`=0, `o_tick_count`=0, divider counter 0, skip flag 0, instr-step "ticked" flag 0.
- Divider: in RUNNING/STEPPING the counter increments each cycle. A **slot** occurs when counter == `i_div`; the counter then returns to 0. The counter clears on every state entry. Changing `i_div` mid-count takes effect immediately; a counter above the new `i_div` does not produce a slot until it wraps at 2^DIV_WIDTH (allowed behaviour, documented).
- At each slot, resolve in strict priority order:
  1. `i_halt`=1 → HALTED, no tick.
  2. Breakpoint match → BREAK, no tick. A match requires `i_instr_boundary`=1, some enabled k with `i_bp_addr[k]`==`i_pc`, and skip=0. The lowest k wins and is latched into `o_bp_index`.
  3. `i_stop` seen since the last slot → STOPPED, no tick. `i_stop` is latched.
  4. STEP_INSTR with "ticked"=1 and `i_instr_boundary`=1 → STOPPED, no tick.
  5. Otherwise issue a tick. `o_clk_en`=1 the next cycle, `o_tick_count`+1, skip←0, ticked←1. STEP_CYCLE → STOPPED after its single tick.
- `i_start` accepted only in STOPPED or BREAK; ignored in RUNNING, STEPPING and HALTED. From BREAK it sets skip=1 and clears `o_bp_hit`, so execution leaves the breakpoint PC. `i_start` also clears ticked and the stop latch.
- HALTED is left only by reset.
- `i_start` and `i_stop` in the same cycle: start wins, and stop is not latched.

## Timing
- `i_start` in cycle t → state valid at t+1. With `i_div`=D, the first slot is at t+1+D and the first `o_clk_en` at t+2+D. Later pulses follow every D+1 cycles.
- `o_clk_en` is never high for two consecutive cycles unless D=0. With D=0 in RUN it is continuously high from t+2.
- `o_state`, `o_bp_hit` and `o_bp_index` update in the cycle after the deciding slot.
- Reset asserted mid-run: `o_clk_en` is 0 in the cycle after the reset edge, and all outputs take their reset values.
- Breakpoint/halt inputs are sampled only in slot cycles. Between slots they are ignored.

## Test plan
- Divider, RUN: D=2 → `o_clk_en` first high at t+4, then every 3 cycles. 10 ticks gives `o_tick_count`=10. D=0 → continuous high from t+2.
- STEP_CYCLE, D=0: exactly one `o_clk_en` pulse, `o_tick_count`=1, `o_state` returns to 0. A second `i_start` gives exactly one more pulse.
- STEP_INSTR with boundary high every 5th slot: exactly 5 ticks, then STOPPED with boundary high.
- Breakpoint: bp0=0x0010 and bp2=0x0010 enabled; PC reaches 0x0010 at boundary → BREAK with `o_bp_index`=0 and no tick at that slot. `i_start` → resumes with ticks and does not re-break at 0x0010 on that entry.
- HLT: `i_halt`=1 at a slot with a matching breakpoint also present → HALTED (not BREAK), tick count frozen. `i_start` is ignored; only `i_rst_n`=0 returns to STOPPED.
- Start/stop races: `i_start` and `i_stop` in the same cycle → RUNNING. Reset pulsed mid-run → `o_clk_en`=0 at the next cycle and `o_tick_count`=0.

Source files
------------

// File: rtl/exec_controller.sv
// exec_controller: programmable clock-enable generator with run/step modes, PC breakpoints and sticky HLT capture
module exec_controller #(
    parameter int DIV_WIDTH = 16,
    parameter int PC_WIDTH  = 16,
    parameter int NUM_BP    = 4,
    parameter int CNT_WIDTH = 32,
    localparam int BPI_WIDTH = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic [1:0]                 i_mode,
    input  logic                       i_start,
    input  logic                       i_stop,
    input  logic [DIV_WIDTH-1:0]       i_div,
    input  logic                       i_halt,
    input  logic                       i_instr_boundary,
    input  logic [PC_WIDTH-1:0]        i_pc,
    input  logic [NUM_BP-1:0]          i_bp_en,
    input  logic [NUM_BP*PC_WIDTH-1:0] i_bp_addr,
    output logic                       o_clk_en,
    output logic [2:0]                 o_state,
    output logic                       o_bp_hit,
    output logic [BPI_WIDTH-1:0]       o_bp_index,
    output logic [CNT_WIDTH-1:0]       o_tick_count
);

    typedef enum logic [2:0] {
        ST_STOPPED  = 3'd0,
        ST_RUNNING  = 3'd1,
        ST_STEPPING = 3'd2,
        ST_BREAK    = 3'd3,
        ST_HALTED   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        M_RUN   = 2'd0,
        M_CYCLE = 2'd1,
        M_INSTR = 2'd2
    } mode_t;

    state_t                 state_q, state_d;
    mode_t                  mode_q, mode_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   skip_q, skip_d;
    logic                   ticked_q, ticked_d;
    logic                   stop_q, stop_d;
    logic                   clk_en_q, clk_en_d;
    logic                   bp_hit_q, bp_hit_d;
    logic [BPI_WIDTH-1:0]   bp_index_q, bp_index_d;
    logic [CNT_WIDTH-1:0]   tick_count_q, tick_count_d;

    logic                   bp_match;
    logic [BPI_WIDTH-1:0]   bp_sel;
    logic                   active, start_ok, slot, stop_seen;

    assign active    = (state_q == ST_RUNNING) || (state_q == ST_STEPPING);
    assign start_ok  = i_start && ((state_q == ST_STOPPED) || (state_q == ST_BREAK));
    assign slot      = active && (cnt_q == i_div);
    assign stop_seen = stop_q || i_stop;

    // Find the lowest-index enabled breakpoint whose address equals the current PC
    always_comb begin
        bp_match = 1'b0;
        bp_sel   = '0;
        for (int k = NUM_BP - 1; k >= 0; k--) begin
            if (i_bp_en[k] && (i_bp_addr[k*PC_WIDTH +: PC_WIDTH] == i_pc)) begin
                bp_match = 1'b1;
                bp_sel   = BPI_WIDTH'(k);
            end
        end
    end

    // Next state: accept start, otherwise resolve each divider slot by halt > break > stop > instr-step end > tick
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        cnt_d        = cnt_q;
        skip_d       = skip_q;
        ticked_d     = ticked_q;
        stop_d       = stop_q;
        clk_en_d     = 1'b0;
        bp_hit_d     = bp_hit_q;
        bp_index_d   = bp_index_q;
        tick_count_d = tick_count_q;
        if (start_ok) begin
            mode_d   = (i_mode == 2'd0) ? M_RUN : (i_mode == 2'd2) ? M_INSTR : M_CYCLE;
            state_d  = (i_mode == 2'd0) ? ST_RUNNING : ST_STEPPING;
            cnt_d    = '0;
            ticked_d = 1'b0;
            stop_d   = 1'b0;
            if (state_q == ST_BREAK) begin
                skip_d   = 1'b1;
                bp_hit_d = 1'b0;
            end
        end else if (slot) begin
            cnt_d  = '0;
            stop_d = 1'b0;
            if (i_halt) begin
                state_d = ST_HALTED;
            end else if (i_instr_boundary && bp_match && !skip_q) begin
                state_d    = ST_BREAK;
                bp_hit_d   = 1'b1;
                bp_index_d = bp_sel;
            end else if (stop_seen) begin
                state_d = ST_STOPPED;
            end else if ((mode_q == M_INSTR) && ticked_q && i_instr_boundary) begin
                state_d = ST_STOPPED;
            end else begin
                clk_en_d     = 1'b1;
                tick_count_d = tick_count_q + 1'b1;
                skip_d       = 1'b0;
                ticked_d     = 1'b1;
                state_d      = (mode_q == M_CYCLE) ? ST_STOPPED : state_q;
            end
        end else begin
            cnt_d  = active ? cnt_q + 1'b1 : '0;
            stop_d = stop_seen;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_STOPPED;
            mode_q       <= M_RUN;
            cnt_q        <= '0;
            skip_q       <= 1'b0;
            ticked_q     <= 1'b0;
            stop_q       <= 1'b0;
            clk_en_q     <= 1'b0;
            bp_hit_q     <= 1'b0;
            bp_index_q   <= '0;
            tick_count_q <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            skip_q       <= skip_d;
            ticked_q     <= ticked_d;
            stop_q       <= stop_d;
            clk_en_q     <= clk_en_d;
            bp_hit_q     <= bp_hit_d;
            bp_index_q   <= bp_index_d;
            tick_count_q <= tick_count_d;
        end
    end

    assign o_clk_en     = clk_en_q;
    assign o_state      = state_q;
    assign o_bp_hit     = bp_hit_q;
    assign o_bp_index   = bp_index_q;
    assign o_tick_count = tick_count_q;

endmodule
